// File: rtl/bp_fe_bht_update_sched_if.sv
// Update-in / BHT-write-out handshake bundle for the BHT update scheduler.
// slave is the scheduler's view; master is the backend/BHT side.
interface bp_fe_bht_update_sched_if #(
    parameter int bht_idx_width_p    = 8,
    parameter int bht_offset_width_p = 2,
    parameter int ghist_width_p      = 4,
    parameter int bht_row_width_p    = 8
);
    logic                          upd_v_i;
    logic [bht_idx_width_p-1:0]    upd_idx_i;
    logic [bht_offset_width_p-1:0] upd_offset_i;
    logic [ghist_width_p-1:0]      upd_ghist_i;
    logic [bht_row_width_p-1:0]    upd_val_i;
    logic                          upd_correct_i;
    logic                          upd_ready_o;

    logic                          w_v_o;
    logic [bht_idx_width_p-1:0]    w_idx_o;
    logic [bht_offset_width_p-1:0] w_offset_o;
    logic [ghist_width_p-1:0]      w_ghist_o;
    logic [bht_row_width_p-1:0]    w_val_o;
    logic                          w_correct_o;
    logic                          w_yumi_i;

    modport slave (
        input  upd_v_i, upd_idx_i, upd_offset_i, upd_ghist_i, upd_val_i, upd_correct_i,
        output upd_ready_o,
        output w_v_o, w_idx_o, w_offset_o, w_ghist_o, w_val_o, w_correct_o,
        input  w_yumi_i
    );

    modport master (
        output upd_v_i, upd_idx_i, upd_offset_i, upd_ghist_i, upd_val_i, upd_correct_i,
        input  upd_ready_o,
        input  w_v_o, w_idx_o, w_offset_o, w_ghist_o, w_val_o, w_correct_o,
        output w_yumi_i
    );
endinterface

// File: rtl/bp_fe_bht_update_sched.sv
// Queues BHT updates onto the single write port, gated by init, with retry and starvation drop.
// Optional tail coalescing is enabled by defining BP_FE_BHT_UPD_COALESCE_EN.
module bp_fe_bht_update_sched #(
    parameter int bht_idx_width_p    = 8,
    parameter int bht_offset_width_p = 2,
    parameter int ghist_width_p      = 4,
    parameter int bht_row_width_p    = 8,
    parameter int els_p              = 4,
    parameter int max_stall_p        = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         init_done_i,
    input  logic                         flush_i,
    bp_fe_bht_update_sched_if.slave      bus,
    output logic                         drop_o,
    output logic [$clog2(els_p+1)-1:0]   count_o
);
    localparam int ptr_w   = $clog2(els_p);
    localparam int cnt_w   = $clog2(els_p + 1);
    localparam int stall_w = (max_stall_p > 1) ? $clog2(max_stall_p) : 1;

    localparam logic [1:0] e_reset     = 2'd0;
    localparam logic [1:0] e_wait_init = 2'd1;
    localparam logic [1:0] e_run       = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [ptr_w-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [cnt_w-1:0]   count_reg, count_next;
    logic [stall_w-1:0] stall_reg;

    logic [bht_idx_width_p-1:0]    idx_mem     [els_p];
    logic [bht_offset_width_p-1:0] offset_mem  [els_p];
    logic [ghist_width_p-1:0]      ghist_mem   [els_p];
    logic [bht_row_width_p-1:0]    val_mem     [els_p];
    logic                          correct_mem [els_p];

    logic run, not_full, w_v, coalesce_hit, accept, alloc, stall_hit, drop, pop;

    assign run       = (state_reg == e_run);
    assign not_full  = (count_reg < cnt_w'(els_p));
    assign w_v       = run & (count_reg != '0);
    assign stall_hit = (stall_reg == stall_w'(max_stall_p - 1));

`ifdef BP_FE_BHT_UPD_COALESCE_EN
    logic [ptr_w-1:0] tail_ptr;
    logic             merge;
    assign tail_ptr = wr_ptr_reg - 1'b1;
    // Needing two entries keeps the merge target distinct from the head being written out.
    assign coalesce_hit = (count_reg >= cnt_w'(2))
                        & (idx_mem[tail_ptr]    == bus.upd_idx_i)
                        & (ghist_mem[tail_ptr]  == bus.upd_ghist_i)
                        & (offset_mem[tail_ptr] == bus.upd_offset_i);
    assign merge = accept & coalesce_hit;
`else
    assign coalesce_hit = 1'b0;
`endif

    assign bus.upd_ready_o = run & (not_full | coalesce_hit);
    assign accept          = bus.upd_v_i & bus.upd_ready_o & ~flush_i;
    assign alloc           = accept & ~coalesce_hit;

    assign drop = w_v & ~bus.w_yumi_i & stall_hit & ~flush_i;
    assign pop  = (w_v & bus.w_yumi_i & ~flush_i) | drop;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            e_reset:     state_next = e_wait_init;
            e_wait_init: if (init_done_i) state_next = e_run;
            e_run:       state_next = e_run;
            default:     state_next = e_reset;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (flush_i)
            count_next = '0;
        else
            count_next = count_reg + cnt_w'(alloc) - cnt_w'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg  <= e_reset;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            stall_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (flush_i) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                stall_reg  <= '0;
            end else begin
                if (alloc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (pop)
                    stall_reg <= '0;
                else if (w_v)
                    stall_reg <= stall_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; contents only matter once counted as occupied.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            idx_mem[wr_ptr_reg]     <= bus.upd_idx_i;
            offset_mem[wr_ptr_reg]  <= bus.upd_offset_i;
            ghist_mem[wr_ptr_reg]   <= bus.upd_ghist_i;
            val_mem[wr_ptr_reg]     <= bus.upd_val_i;
            correct_mem[wr_ptr_reg] <= bus.upd_correct_i;
        end
`ifdef BP_FE_BHT_UPD_COALESCE_EN
        if (merge) begin
            val_mem[tail_ptr]     <= bus.upd_val_i;
            correct_mem[tail_ptr] <= bus.upd_correct_i;
        end
`endif
    end

    assign bus.w_v_o       = w_v;
    assign bus.w_idx_o     = idx_mem[rd_ptr_reg];
    assign bus.w_offset_o  = offset_mem[rd_ptr_reg];
    assign bus.w_ghist_o   = ghist_mem[rd_ptr_reg];
    assign bus.w_val_o     = val_mem[rd_ptr_reg];
    assign bus.w_correct_o = correct_mem[rd_ptr_reg];
    assign drop_o          = drop;
    assign count_o         = count_reg;
endmodule

// File: tb/tb_bp_fe_bht_update_sched.sv
// Directed bench for bp_fe_bht_update_sched: queue-level reference model checked every cycle
// plus literal expectations for init gating, ordering, starvation, flush and coalescing.
module tb_bp_fe_bht_update_sched;
    localparam int IW = 8, OW = 2, GW = 4, VW = 8;
    localparam int ELS = 4, MAXS = 8;
`ifdef BP_FE_BHT_UPD_COALESCE_EN
    localparam bit coal_en = 1'b1;
`else
    localparam bit coal_en = 1'b0;
`endif

    typedef struct {
        logic [IW-1:0] idx;
        logic [OW-1:0] off;
        logic [GW-1:0] gh;
        logic [VW-1:0] val;
        logic          c;
    } ent_t;

    logic clk = 1'b0;
    logic reset_i, init_done_i, flush_i, drop_o;
    logic [$clog2(ELS+1)-1:0] count_o;
    int checks = 0;
    int failures = 0;

    bp_fe_bht_update_sched_if #(.bht_idx_width_p(IW), .bht_offset_width_p(OW),
                                .ghist_width_p(GW), .bht_row_width_p(VW)) bus ();

    bp_fe_bht_update_sched #(
        .bht_idx_width_p(IW), .bht_offset_width_p(OW), .ghist_width_p(GW),
        .bht_row_width_p(VW), .els_p(ELS), .max_stall_p(MAXS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .init_done_i(init_done_i), .flush_i(flush_i),
        .bus(bus), .drop_o(drop_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 = just reset, 1 = awaiting init, 2 = running.
    ent_t mq[$];
    int   phase = 0;
    int   mstall = 0;
    bit   live = 1'b0;

    always @(negedge clk) begin
        bit   run, exp_wv, exp_rdy, exp_drop, hit, acc, do_pop;
        ent_t e;
        run = (phase == 2);
        hit = coal_en && mq.size() >= 2 &&
              mq[mq.size()-1].idx == bus.upd_idx_i &&
              mq[mq.size()-1].gh  == bus.upd_ghist_i &&
              mq[mq.size()-1].off == bus.upd_offset_i;
        exp_rdy  = run && (mq.size() < ELS || hit);
        exp_wv   = run && mq.size() != 0;
        exp_drop = exp_wv && !bus.w_yumi_i && mstall == MAXS-1 && !flush_i;
        if (live) begin
            chk("m_ready", bus.upd_ready_o, exp_rdy);
            chk("m_wv",    bus.w_v_o,       exp_wv);
            chk("m_drop",  drop_o,          exp_drop);
            chk("m_count", count_o,         mq.size());
            if (exp_wv) begin
                chk("m_idx",     bus.w_idx_o,     mq[0].idx);
                chk("m_offset",  bus.w_offset_o,  mq[0].off);
                chk("m_ghist",   bus.w_ghist_o,   mq[0].gh);
                chk("m_val",     bus.w_val_o,     mq[0].val);
                chk("m_correct", bus.w_correct_o, mq[0].c);
            end
        end
        if (reset_i) begin
            live = 1'b1;
            phase = 0;
            mq.delete();
            mstall = 0;
        end else begin
            if (phase == 0) phase = 1;
            else if (phase == 1 && init_done_i) phase = 2;
            if (flush_i) begin
                mq.delete();
                mstall = 0;
            end else begin
                acc = bus.upd_v_i && exp_rdy;
                do_pop = (exp_wv && bus.w_yumi_i) || exp_drop;
                if (acc && hit) begin
                    mq[mq.size()-1].val = bus.upd_val_i;
                    mq[mq.size()-1].c   = bus.upd_correct_i;
                    $display("merge idx=%0h val=%0h correct=%0b", bus.upd_idx_i, bus.upd_val_i, bus.upd_correct_i);
                end
                if (do_pop) begin
                    $display("%s idx=%0h", exp_drop ? "drop" : "write", mq[0].idx);
                    void'(mq.pop_front());
                end
                if (acc && !hit) begin
                    e.idx = bus.upd_idx_i;  e.off = bus.upd_offset_i; e.gh = bus.upd_ghist_i;
                    e.val = bus.upd_val_i;  e.c   = bus.upd_correct_i;
                    mq.push_back(e);
                    $display("enq idx=%0h val=%0h correct=%0b", e.idx, e.val, e.c);
                end
                if (do_pop) mstall = 0;
                else if (exp_wv) mstall++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [IW-1:0] i, input logic [OW-1:0] o, input logic [GW-1:0] g,
                       input logic [VW-1:0] v, input logic c);
        bus.upd_v_i = 1'b1;  bus.upd_idx_i = i;  bus.upd_offset_i = o;
        bus.upd_ghist_i = g; bus.upd_val_i = v;  bus.upd_correct_i = c;
    endtask

    initial begin
        reset_i = 1'b1; init_done_i = 1'b0; flush_i = 1'b0;
        enq('0, '0, '0, '0, 1'b0);
        bus.upd_v_i = 1'b0; bus.w_yumi_i = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", bus.upd_ready_o, 0);
        chk("rst_wv", bus.w_v_o, 0);
        chk("rst_drop", drop_o, 0);
        chk("rst_count", count_o, 0);
        tick();

        // Init gating with a pending update request
        reset_i = 1'b0;
        enq(8'h07, 2'd0, 4'd0, 8'h00, 1'b1);
        repeat (20) begin
            @(negedge clk);
            chk("gate_ready", bus.upd_ready_o, 0);
            chk("gate_wv", bus.w_v_o, 0);
            tick();
        end
        bus.upd_v_i = 1'b0; init_done_i = 1'b1;
        tick();
        @(negedge clk);
        chk("init_ready", bus.upd_ready_o, 1);
        chk("init_wv", bus.w_v_o, 0);
        tick();

        // Ordering and full
        for (int i = 1; i <= 4; i++) begin
            enq(IW'(i), OW'(i), GW'(i), VW'(i * 16), 1'b1);
            tick();
        end
        enq(8'h08, 2'd0, 4'd0, 8'h88, 1'b0);
        @(negedge clk);
        chk("full_count", count_o, 4);
        chk("full_ready", bus.upd_ready_o, 0);
        chk("full_head", bus.w_idx_o, 1);
        tick();
        @(negedge clk);
        chk("full_hold", bus.w_idx_o, 1);
        chk("full_count2", count_o, 4);
        tick();
        bus.upd_v_i = 1'b0; bus.w_yumi_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("order_idx", bus.w_idx_o, k);
            tick();
        end
        bus.w_yumi_i = 1'b0;
        @(negedge clk);
        chk("drain_wv", bus.w_v_o, 0);
        chk("drain_count", count_o, 0);
        tick();

        // Starvation drop on the 8th refused cycle
        enq(8'h11, 2'd1, 4'd3, 8'h5a, 1'b1);
        tick();
        bus.upd_v_i = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk("starve_wv", bus.w_v_o, 1);
            chk("starve_drop", drop_o, (n == 8) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        chk("starve_count", count_o, 0);
        tick();

        // Flush beats enqueue and yumi
        for (int i = 0; i < 3; i++) begin
            enq(IW'(8'h21 + i), 2'd0, 4'd0, 8'h01, 1'b1);
            tick();
        end
        bus.upd_v_i = 1'b0;
        @(negedge clk);
        chk("pre_flush_count", count_o, 3);
        tick();
        flush_i = 1'b1; bus.w_yumi_i = 1'b1;
        enq(8'h24, 2'd0, 4'd0, 8'h02, 1'b1);
        @(negedge clk);
        chk("flush_drop", drop_o, 0);
        tick();
        flush_i = 1'b0; bus.upd_v_i = 1'b0; bus.w_yumi_i = 1'b0;
        @(negedge clk);
        chk("flush_count", count_o, 0);
        chk("flush_wv", bus.w_v_o, 0);
        tick();

        // Simultaneous enqueue/dequeue at count 1; init_done deassertion is ignored
        init_done_i = 1'b0;
        enq(8'h31, 2'd2, 4'd1, 8'h31, 1'b0);
        tick();
        enq(8'h32, 2'd3, 4'd2, 8'h32, 1'b1);
        bus.w_yumi_i = 1'b1;
        @(negedge clk);
        chk("simul_count", count_o, 1);
        chk("simul_head", bus.w_idx_o, 8'h31);
        chk("simul_ready", bus.upd_ready_o, 1);
        tick();
        bus.upd_v_i = 1'b0; bus.w_yumi_i = 1'b0;
        @(negedge clk);
        chk("simul_count2", count_o, 1);
        chk("simul_newhead", bus.w_idx_o, 8'h32);
        tick();
        bus.w_yumi_i = 1'b1;
        tick();
        bus.w_yumi_i = 1'b0;
        tick();

        // Coalescing against the tail
        enq(8'h05, 2'd0, 4'd0, 8'ha5, 1'b1); tick();
        enq(8'h09, 2'd0, 4'd0, 8'hb9, 1'b1); tick();
        enq(8'h09, 2'd0, 4'd0, 8'hc3, 1'b0); tick();
        bus.upd_v_i = 1'b0; bus.w_yumi_i = 1'b1;
        @(negedge clk);
        chk("coal_count", count_o, coal_en ? 2 : 3);
        chk("coal_head", bus.w_idx_o, 8'h05);
        tick();
        @(negedge clk);
        chk("coal_tail_idx", bus.w_idx_o, 8'h09);
        chk("coal_tail_correct", bus.w_correct_o, coal_en ? 0 : 1);
        chk("coal_tail_val", bus.w_val_o, coal_en ? 8'hc3 : 8'hb9);
        tick();
        @(negedge clk);
        chk("coal_third_wv", bus.w_v_o, coal_en ? 0 : 1);
        tick();
        bus.w_yumi_i = 1'b0;
        @(negedge clk);
        chk("coal_empty", count_o, 0);
        tick();

        // Mid-operation reset then re-init
        enq(8'h51, 2'd0, 4'd0, 8'h51, 1'b1); tick();
        enq(8'h52, 2'd0, 4'd0, 8'h52, 1'b1); tick();
        bus.upd_v_i = 1'b0; reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        chk("mrst_count", count_o, 0);
        chk("mrst_ready", bus.upd_ready_o, 0);
        chk("mrst_wv", bus.w_v_o, 0);
        tick();
        @(negedge clk);
        chk("mrst_wait_ready", bus.upd_ready_o, 0);
        tick();
        init_done_i = 1'b1;
        tick();
        @(negedge clk);
        chk("mrst_run_ready", bus.upd_ready_o, 1);
        tick();

        // Yumi while empty is ignored; the enqueue still lands
        bus.w_yumi_i = 1'b1;
        enq(8'h41, 2'd1, 4'd5, 8'h41, 1'b1);
        @(negedge clk);
        chk("ill_yumi_wv", bus.w_v_o, 0);
        tick();
        bus.upd_v_i = 1'b0; bus.w_yumi_i = 1'b0;
        @(negedge clk);
        chk("ill_yumi_count", count_o, 1);
        chk("ill_yumi_head", bus.w_idx_o, 8'h41);
        tick();
        bus.w_yumi_i = 1'b1;
        tick();
        bus.w_yumi_i = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
